// File: rtl/sram_resp_if.sv
// sram_resp_if: strobe, preload and error bundle between the tinycpu side and sram_resp
//   master: drives addr/din/den/cen/wen/oen, load_*, err_clr; observes dq/dq_oe, load_ready, cpu_hold, load_count, err_*
//   slave:  the responder, mirror image of master
interface sram_resp_if #(parameter int DW = 8, parameter int AW = 8);
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic den, cen, wen, oen;
  logic [DW-1:0] dq;
  logic dq_oe;
  logic load_start, load_valid, load_last;
  logic [DW-1:0] load_data;
  logic load_ready, cpu_hold;
  logic [AW:0] load_count;
  logic err_clr, err_bus, err_par;
  modport master (
    output addr, din, den, cen, wen, oen, load_start, load_valid, load_data, load_last, err_clr,
    input  dq, dq_oe, load_ready, cpu_hold, load_count, err_bus, err_par
  );
  modport slave (
    input  addr, din, den, cen, wen, oen, load_start, load_valid, load_data, load_last, err_clr,
    output dq, dq_oe, load_ready, cpu_hold, load_count, err_bus, err_par
  );
endinterface

// File: rtl/sram_resp.sv
// sram_resp: SRAM strobe responder with combinational reads and host byte-stream preload
//   clk, rst (async, active-low); bus (sram_resp_if.slave): CPU strobes/addr/data, zero-latency dq,
//   host preload stream with cpu_hold, saturating load_count, sticky err_bus/err_par cleared by err_clr.
//   Optional SRAM_RESP_PARITY_EN: stores an even-parity bit per word and flags mismatches on CPU reads.
module sram_resp #(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input logic clk,
  input logic rst,
  sram_resp_if.slave bus
);
`ifdef SRAM_RESP_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif
  typedef enum logic {SERVE, LOAD} state_t;
  state_t r_state, w_next;
  logic [MW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_ptr;
  logic [AW:0] r_cnt;
  logic r_err_bus, r_err_par;
  logic w_serve, w_in_range, w_rd, w_wr, w_beat, w_bus_err, w_par_err;
  logic [MW-1:0] w_word, w_cpu_wd, w_ld_wd;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= SERVE;
    else r_state <= w_next;
  // load_start restarts from either state; a beat carrying it is dropped, so it never ends the load
  always_comb w_next = bus.load_start ? LOAD : (w_beat && bus.load_last) ? SERVE : r_state;
  always_comb begin
    w_serve    = r_state == SERVE;
    w_in_range = int'(bus.addr) < DEPTH;
    w_word     = r_mem[bus.addr];
    w_rd       = w_serve & ~bus.cen & ~bus.oen & bus.wen;
    w_wr       = w_serve & ~bus.cen & ~bus.wen;
    w_beat     = ~w_serve & bus.load_valid & ~bus.load_start;
    w_bus_err  = w_serve & ((bus.den & w_rd) | (w_wr & ~bus.den) | (~bus.cen & ~bus.oen & ~bus.wen) |
                            (~bus.cen & ~w_in_range));
`ifdef SRAM_RESP_PARITY_EN
    w_cpu_wd   = {^bus.din, bus.din};
    w_ld_wd    = {^bus.load_data, bus.load_data};
    w_par_err  = w_rd & w_in_range & (^w_word);
`else
    w_cpu_wd   = bus.din;
    w_ld_wd    = bus.load_data;
    w_par_err  = 1'b0;
`endif
    bus.dq_oe      = w_rd;
    bus.dq         = (w_rd & w_in_range) ? w_word[DW-1:0] : '0;
    bus.load_ready = ~w_serve;
    bus.cpu_hold   = ~w_serve;
    bus.load_count = r_cnt;
    bus.err_bus    = r_err_bus;
    bus.err_par    = r_err_par;
  end
  always_ff @(posedge clk)
    if (w_wr && w_in_range) r_mem[bus.addr] <= w_cpu_wd;
    else if (w_beat) r_mem[r_ptr] <= w_ld_wd;
  // a set condition outranks err_clr in the same cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_err_bus <= 1'b0;
      r_err_par <= 1'b0;
    end else begin
      if (bus.load_start) begin
        r_ptr <= '0;
        r_cnt <= '0;
      end else if (w_beat) begin
        r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
        r_cnt <= (r_cnt == (AW + 1)'(DEPTH)) ? r_cnt : r_cnt + 1'b1;
      end
      r_err_bus <= w_bus_err | (r_err_bus & ~bus.err_clr);
      r_err_par <= w_par_err | (r_err_par & ~bus.err_clr);
    end
endmodule

// File: doc/sram_resp.md
# sram_resp

Memory-side responder for the tinycpu SRAM strobe interface. It holds the program/data array, answers the CPU's cen/oen/wen/den strobes and address, and returns read data for instruction fetch and LDM. It also accepts a byte-stream program preload from a host port, during which it holds the CPU off. It sits between the SRAM address/data mux and the CPU control block, which expects combinational read data within the strobe cycle.

## Interface
- DW, 8, data word width
- AW, 8, address width
- DEPTH, 256, number of words (≤ 2^AW)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- addr  in  AW  word address from address mux
- din  in  DW  write data from CPU (valid when den=1)
- den  in  1  CPU is driving write data
- cen  in  1  chip enable, active-low
- wen  in  1  write enable, active-low
- oen  in  1  output enable, active-low
- dq  out  DW  read data to CPU
- dq_oe  out  1  dq valid/driven
- load_start  in  1  pulse: begin preload at address 0
- load_valid  in  1  host byte valid
- load_data  in  DW  host byte
- load_last  in  1  final byte of preload (qualified by load_valid)
- load_ready  out  1  responder accepts host byte
- cpu_hold  out  1  hold CPU in reset while preloading
- load_count  out  AW+1  bytes accepted in current/last preload, saturating at DEPTH
- err_clr  in  1  synchronous clear of sticky error flags
- err_bus  out  1  sticky bus-protocol error
- err_par  out  1  sticky parity error (see Configuration)

## Operation
- FSM states: SERVE, LOAD. Reset -> SERVE.
- SERVE: load_start=1 -> LOAD, load pointer=0, load_count=0.
- LOAD: load_ready=1, cpu_hold=1. Beat = load_valid & load_ready: mem[ptr] <= load_data, ptr++, load_count++ (saturate at DEPTH). Beat with load_last=1 -> SERVE. ptr at DEPTH-1 wraps to 0. load_start in LOAD restarts ptr and load_count at 0 (takes priority over a simultaneous beat, which is dropped).
- CPU read (SERVE only): cen=0, oen=0, wen=1 -> dq = mem[addr] combinationally, dq_oe=1. Otherwise dq=0, dq_oe=0.
- CPU write (SERVE only): at posedge with cen=0, wen=0 -> mem[addr] <= din.
- In LOAD all CPU strobes are ignored: no writes, dq_oe=0.
- addr ≥ DEPTH: reads return 0, writes dropped, err_bus set.
- err_bus set at posedge on any of: den=1 while dq_oe=1 (contention); write with den=0; cen=0 with oen=0 and wen=0; out-of-range access. Cleared only by err_clr or reset; a set condition in the same cycle as err_clr wins.

## Timing
- Reset values: dq=0, dq_oe=0, load_ready=0, cpu_hold=0, load_count=0, err_bus=0, err_par=0, state SERVE. Array contents are not reset.
- Read latency zero: dq valid in the same cycle the strobes are low, so the CPU samples it at the closing edge of FETCH/MEMACC.
- Write committed at the posedge ending the cen=0/wen=0 cycle; a read of that address in the following cycle returns new data.
- Preload: one byte per cycle max; cpu_hold asserts the cycle after load_start and deasserts the cycle after the load_last beat.
- Reset mid-preload: back to SERVE, cpu_hold=0; bytes already written remain.

## Configuration
- SRAM_RESP_PARITY_EN defined: array stores DW+1 bits; even parity generated on every write (CPU and preload); on every CPU read a mismatch sets err_par at the closing posedge.
- Undefined: no parity storage, err_par tied 0.

## Test plan
- Preload 4 bytes 0x41,0x42,0xC0,0x5F (last on 4th) -> cpu_hold high 4 cycles, load_count=4, then reads at addr 0..3 return those bytes with dq_oe=1.
- CPU write: addr=0x10, din=0xA5, den=1, cen=0, wen=0 one cycle -> next cycle read of 0x10 with cen=0, oen=0 gives dq=0xA5, err_bus=0.
- Write with den=0 at addr 0x20 -> array updated with din, err_bus=1; err_clr pulse -> err_bus=0.
- Preload 257 bytes -> address wraps, mem[0] holds byte 257, load_count=256.
- load_start mid-preload after 3 beats, then 2 beats -> load_count=2, mem[0..1] overwritten; assert rst mid-load -> cpu_hold=0, state SERVE.
- With SRAM_RESP_PARITY_EN, force a flipped stored bit at addr 0x05 then read -> err_par=1; without macro err_par stays 0.
